accum_burst_feeder: RTL and testbench

//  Upstream feeder for delay_accumulator. Accepts a complex_t sample stream with valid/ready

---
 rtl/accum_burst_feeder.sv | 163 ++++++++++++++++
 tb/tb_accum_burst_feeder.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/accum_burst_feeder.sv
// FIFO-buffered feeder that emits gap-separated bursts of BURST_LEN samples, each announced by a
// one-cycle next pulse. Optional feature macro ACCUM_FEEDER_ZERO_PAD_EN: flush pads a partial burst with zeros.
module accum_burst_feeder #(
  parameter int BURST_LEN       = 12,
  parameter int FIFO_DEPTH_BITS = 5,
  parameter int GAP_CYCLES      = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [63:0]              in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     flush,
  output logic                     next,
  output logic [63:0]              out_data,
  output logic                     out_valid,
  output logic                     busy,
  output logic [FIFO_DEPTH_BITS:0] fifo_count,
  output logic [15:0]              bursts_sent
);

  localparam int DEPTH = 2 ** FIFO_DEPTH_BITS;
  localparam int CW    = FIFO_DEPTH_BITS + 1;
  localparam int GW    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [CW-1:0] DEPTH_C     = CW'(DEPTH);
  localparam logic [CW-1:0] BURST_C     = CW'(BURST_LEN);
  localparam logic [CW-1:0] BEAT_LAST_C = CW'(BURST_LEN - 1);
  localparam logic [GW-1:0] GAP_LAST_C  = GW'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARM    = 2'd1,
    STREAM = 2'd2,
    GAP    = 2'd3
  } state_t;

  state_t                     state_reg, state_next;
  logic [63:0]                mem [DEPTH];
  logic [FIFO_DEPTH_BITS-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0]              count_reg;
  logic [CW-1:0]              beat_reg;
  logic [CW-1:0]              real_len_reg, real_len_next;
  logic [CW-1:0]              load_idx;
  logic [GW-1:0]              gap_reg;
  logic [63:0]                out_data_reg;
  logic [15:0]                bursts_reg;
  logic                       push, pop, load, arm_flush;

`ifdef ACCUM_FEEDER_ZERO_PAD_EN
  assign arm_flush = flush && (count_reg != '0) && (count_reg < BURST_C);
`else
  logic unused_flush;
  assign unused_flush = flush;
  assign arm_flush    = 1'b0;
`endif

  // No push-through: a full FIFO refuses input even while it is being popped.
  assign in_ready = (count_reg < DEPTH_C);
  assign push     = in_valid && in_ready;

  // The output register is loaded one edge ahead of each beat: at the end of ARM for beat 0
  // and at the end of beat b for beat b+1. Beats past the stored entries load zeros.
  assign load     = (state_reg == ARM) || ((state_reg == STREAM) && (beat_reg != BEAT_LAST_C));
  assign load_idx = (state_reg == ARM) ? '0 : (beat_reg + CW'(1));
  assign pop      = load && (load_idx < real_len_reg);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    real_len_next = real_len_reg;
    next          = 1'b0;
    out_valid     = 1'b0;
    busy          = (state_reg != IDLE);
    case (state_reg)
      IDLE: begin
        if (count_reg >= BURST_C) begin
          state_next    = ARM;
          real_len_next = BURST_C;
        end else if (arm_flush) begin
          state_next    = ARM;
          real_len_next = count_reg;
        end
      end
      ARM: begin
        next       = 1'b1;
        state_next = STREAM;
      end
      STREAM: begin
        out_valid = 1'b1;
        if (beat_reg == BEAT_LAST_C) begin
          state_next = GAP;
        end
      end
      GAP: begin
        if (gap_reg == GAP_LAST_C) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= in_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      beat_reg     <= '0;
      gap_reg      <= '0;
      real_len_reg <= BURST_C;
      out_data_reg <= '0;
      bursts_reg   <= '0;
    end else begin
      real_len_reg <= real_len_next;
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + FIFO_DEPTH_BITS'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + FIFO_DEPTH_BITS'(1);
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
      if (load) begin
        out_data_reg <= pop ? mem[rd_ptr_reg] : '0;
      end
      if (state_reg == ARM) begin
        beat_reg <= '0;
      end else if (state_reg == STREAM) begin
        beat_reg <= beat_reg + CW'(1);
      end
      if (state_reg == STREAM) begin
        gap_reg <= '0;
      end else if (state_reg == GAP) begin
        gap_reg <= gap_reg + GW'(1);
      end
      if ((state_reg == STREAM) && (beat_reg == BEAT_LAST_C)) begin
        bursts_reg <= bursts_reg + 16'd1;
      end
    end
  end

  assign out_data    = out_data_reg;
  assign fifo_count  = count_reg;
  assign bursts_sent = bursts_reg;

endmodule

// File: tb/tb_accum_burst_feeder.sv
// Scoreboard bench for accum_burst_feeder: accepted samples are queued and matched against burst beats.
module tb_accum_burst_feeder;

  localparam int BL    = 12;
  localparam int FDB   = 5;
  localparam int GAPC  = 4;
  localparam int DEPTH = 32;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [63:0]  in_data;
  logic         in_valid;
  logic         in_ready;
  logic         flush;
  logic         next;
  logic [63:0]  out_data;
  logic         out_valid;
  logic         busy;
  logic [FDB:0] fifo_count;
  logic [15:0]  bursts_sent;

  int          n_vec = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          k = 0;
  int          fill = 0;
  logic [15:0] exp_bursts = '0;
  int          last_push_cyc = 0;
  bit          saw_full = 1'b0;
  logic [63:0] sb[$];
  int          next_cycs[$];
  int          exp_beats = 0;

  accum_burst_feeder #(
    .BURST_LEN(BL),
    .FIFO_DEPTH_BITS(FDB),
    .GAP_CYCLES(GAPC)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .in_data(in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .flush(flush),
    .next(next),
    .out_data(out_data),
    .out_valid(out_valid),
    .busy(busy),
    .fifo_count(fifo_count),
    .bursts_sent(bursts_sent)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [63:0] samp(input int idx);
    logic [31:0] w;
    w = 32'h4348_0000 + 32'(idx) * 32'h0001_0000;
    return {w, w};
  endfunction

  // Scoreboard / protocol monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (!reset_n) begin
      sb.delete();
      exp_beats = 0;
    end else begin
      chk("in_ready", 64'(in_ready), 64'(fifo_count < 6'(DEPTH)));
      chk("out_valid", 64'(out_valid), 64'(exp_beats > 0));
      if (out_valid) begin
        if (sb.size() == 0) chk("sb_empty", 64'(sb.size()), 64'd1);
        else chk("out_data", out_data, sb.pop_front());
      end
      if (exp_beats > 0) exp_beats--;
      if (next) begin
        chk("next_in_burst", 64'(exp_beats), 64'd0);
        next_cycs.push_back(cyc);
`ifdef ACCUM_FEEDER_ZERO_PAD_EN
        while (sb.size() < BL) sb.push_back(64'd0);
`endif
        exp_beats = BL;
      end
      if (in_valid && in_ready) sb.push_back(in_data);
    end
  end

  task automatic push_n(input int n);
    int acc;
    int guard;
    acc = 0;
    guard = 0;
    while (acc < n && guard < 5000) begin
      in_valid = 1'b1;
      in_data  = samp(k);
      @(negedge clk);
      if (in_ready) begin
        acc++;
        k++;
        last_push_cyc = cyc;
      end else begin
        saw_full = 1'b1;
        chk("full_count", 64'(fifo_count), 64'(DEPTH));
      end
      @(posedge clk);
      #1;
      guard++;
    end
    in_valid = 1'b0;
    if (acc < n) chk("push_timeout", 64'(acc), 64'(n));
  endtask

  task automatic wait_quiet();
    int g;
    g = 0;
    do begin
      @(negedge clk);
      g++;
    end while (!(busy == 1'b0 && fifo_count < 6'(BL)) && g < 3000);
    if (g >= 3000) chk("quiet_timeout", 64'(g), 64'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic account(input int n);
    fill = fill + n;
    exp_bursts = exp_bursts + 16'(fill / BL);
    fill = fill % BL;
  endtask

  task automatic check_quiet();
    chk("fifo_count", 64'(fifo_count), 64'(fill));
    chk("bursts_sent", 64'(bursts_sent), 64'(exp_bursts));
    chk("sb_left", 64'(sb.size()), 64'(fill));
    chk("busy_idle", 64'(busy), 64'd0);
  endtask

  initial begin
    int b;
    int beats;
    int g;
    int n;
    reset_n  = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    flush    = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_next", 64'(next), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", out_data, 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_fifo_count", 64'(fifo_count), 64'd0);
    chk("rst_bursts", 64'(bursts_sent), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2 reset_n = 1'b1;
    @(posedge clk);
    #1;

    // 1: single burst and arm latency
    push_n(12);
    wait_quiet();
    account(12);
    check_quiet();
    chk("t1_next_count", 64'(next_cycs.size()), 64'd1);
    if (next_cycs.size() >= 1) chk("t1_next_latency", 64'(next_cycs[0] - last_push_cyc), 64'd2);

    // 2: back-to-back bursts
    b = next_cycs.size();
    push_n(24);
    wait_quiet();
    account(24);
    check_quiet();
    chk("t2_next_count", 64'(next_cycs.size() - b), 64'd2);
    if (next_cycs.size() - b >= 2) chk("t2_next_spacing", 64'(next_cycs[b+1] - next_cycs[b]), 64'(BL + GAPC + 2));

    // 3: saturate the FIFO with continuous input, then realign to empty
    saw_full = 1'b0;
    push_n(150);
    wait_quiet();
    account(150);
    check_quiet();
    chk("t3_saw_full", 64'(saw_full), 64'd1);
    n = (BL - fill) % BL;
    push_n(n);
    wait_quiet();
    account(n);
    check_quiet();

    // 4: partial burst and flush
    b = next_cycs.size();
    push_n(5);
    account(5);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
`ifdef ACCUM_FEEDER_ZERO_PAD_EN
    wait_quiet();
    exp_bursts = exp_bursts + 16'd1;
    fill = 0;
    check_quiet();
    chk("t4_flush_next", 64'(next_cycs.size() - b), 64'd1);
`else
    repeat (30) @(posedge clk);
    #1;
    check_quiet();
    chk("t4_no_next", 64'(next_cycs.size() - b), 64'd0);
`endif

    // 5: asynchronous reset in the 6th stream beat
    push_n(BL - fill);
    beats = 0;
    g = 0;
    while (beats < 6 && g < 100) begin
      @(negedge clk);
      if (out_valid) beats++;
      g++;
    end
    chk("t5_reached_beat6", 64'(beats), 64'd6);
    #1 reset_n = 1'b0;
    #1;
    chk("t5_next", 64'(next), 64'd0);
    chk("t5_out_valid", 64'(out_valid), 64'd0);
    chk("t5_busy", 64'(busy), 64'd0);
    chk("t5_fifo_count", 64'(fifo_count), 64'd0);
    chk("t5_bursts", 64'(bursts_sent), 64'd0);
    @(posedge clk);
    @(negedge clk);
    #2 reset_n = 1'b1;
    @(posedge clk);
    #1;
    fill = 0;
    exp_bursts = '0;
    chk("t5_in_ready", 64'(in_ready), 64'd1);
    chk("t5_out_data", out_data, 64'd0);
    check_quiet();

    // 6: bursts_sent wraps from 0xFFFF
    @(negedge clk);
    force dut.bursts_reg = 16'hFFFF;
    @(negedge clk);
    release dut.bursts_reg;
    @(posedge clk);
    #1;
    exp_bursts = 16'hFFFF;
    chk("t6_preload", 64'(bursts_sent), 64'(exp_bursts));
    push_n(12);
    wait_quiet();
    account(12);
    check_quiet();
    chk("t6_wrapped", 64'(bursts_sent), 64'd0);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

endmodule
